// File: rtl/fc_addr_demux.sv
// fc_addr_demux: routes one upstream request channel to N_PORTS downstream
// masters by address window. Unmapped addresses are answered locally with an
// error response one cycle after grant. Responses return in request order by
// only allowing a new target once all requests to the previous target have
// been answered.
module fc_addr_demux #(
  parameter int N_PORTS         = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [N_PORTS-1:0][ADDR_WIDTH-1:0] REGION_START = {32'h1C08_0000, 32'h1C00_0000},
  parameter logic [N_PORTS-1:0][ADDR_WIDTH-1:0] REGION_END   = {32'h1C10_0000, 32'h1C08_0000},
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hBADA_CCE5
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  // upstream request
  input  logic                                    s_req_i,
  input  logic [ADDR_WIDTH-1:0]                   s_add_i,
  input  logic                                    s_wen_i,
  input  logic [DATA_WIDTH-1:0]                   s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]                 s_be_i,
  // upstream grant / response
  output logic                                    s_gnt_o,
  output logic                                    s_r_valid_o,
  output logic [DATA_WIDTH-1:0]                   s_r_rdata_o,
  output logic                                    s_r_opc_o,
  // downstream requests
  output logic [N_PORTS-1:0]                      m_req_o,
  output logic [N_PORTS-1:0][ADDR_WIDTH-1:0]      m_add_o,
  output logic [N_PORTS-1:0]                      m_wen_o,
  output logic [N_PORTS-1:0][DATA_WIDTH-1:0]      m_wdata_o,
  output logic [N_PORTS-1:0][DATA_WIDTH/8-1:0]    m_be_o,
  // downstream grants / responses
  input  logic [N_PORTS-1:0]                      m_gnt_i,
  input  logic [N_PORTS-1:0]                      m_r_valid_i,
  input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]      m_r_rdata_i,
  input  logic [N_PORTS-1:0]                      m_r_opc_i,
  // status
  output logic [3:0]                              outstanding_o,
  output logic [15:0]                             unmapped_cnt_o
);

  // Target code N_PORTS stands for "unmapped".
  localparam int               TGT_W        = $clog2(N_PORTS + 1);
  localparam logic [TGT_W-1:0] TGT_UNMAPPED = TGT_W'(N_PORTS);
  localparam logic [3:0]       OUT_MAX      = 4'(MAX_OUTSTANDING);

  logic [TGT_W-1:0] dec_tgt;
  logic [TGT_W-1:0] cur_tgt;
  logic             dec_unmapped;
  logic             cur_unmapped;
  logic [3:0]       outstanding;
  logic             unm_pend;
  logic             unm_rd;
  logic [15:0]      unmapped_cnt;
  logic             stall;
  logic             tgt_gnt;
  logic             accept;
  logic             rsp_valid;

  // Address decode; scanning downward lets the lowest matching port win.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    dec_tgt = TGT_UNMAPPED;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (s_add_i >= REGION_START[i] && s_add_i < REGION_END[i]) dec_tgt = TGT_W'(i);
    end
  end

  assign dec_unmapped = (dec_tgt == TGT_UNMAPPED);
  assign cur_unmapped = (cur_tgt == TGT_UNMAPPED);

  // Hold off when full, or when switching targets would break response order.
  assign stall = (outstanding == OUT_MAX) || ((outstanding != '0) && (dec_tgt != cur_tgt));

  // Grant from the decoded port; the local error responder always grants.
  always_comb begin
    tgt_gnt = 1'b1;
    for (int i = 0; i < N_PORTS; i++) begin
      if (dec_tgt == TGT_W'(i)) tgt_gnt = m_gnt_i[i];
    end
  end

  assign s_gnt_o = s_req_i & ~stall & tgt_gnt;
  assign accept  = s_gnt_o;

  // Request fan-out: payload broadcast, request only to the decoded port.
  always_comb begin
    m_req_o   = '0;
    m_add_o   = '0;
    m_wen_o   = '0;
    m_wdata_o = '0;
    m_be_o    = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      m_req_o[i]   = s_req_i & ~stall & (dec_tgt == TGT_W'(i));
      m_add_o[i]   = s_add_i;
      m_wen_o[i]   = s_wen_i;
      m_wdata_o[i] = s_wdata_i;
      m_be_o[i]    = s_be_i;
    end
  end

  // Response path: only the current target may answer, and only while busy.
  always_comb begin
    rsp_valid   = cur_unmapped & unm_pend;
    s_r_rdata_o = unm_rd ? ERR_RDATA : '0;
    s_r_opc_o   = 1'b1;
    for (int i = 0; i < N_PORTS; i++) begin
      if (cur_tgt == TGT_W'(i)) begin
        rsp_valid   = m_r_valid_i[i];
        s_r_rdata_o = m_r_rdata_i[i];
        s_r_opc_o   = m_r_opc_i[i];
      end
    end
    s_r_valid_o = rsp_valid & (outstanding != '0);
  end

  // Transaction tracking: target, in-flight count, local error response.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      cur_tgt      <= '0;
      outstanding  <= '0;
      unm_pend     <= 1'b0;
      unm_rd       <= 1'b0;
      unmapped_cnt <= '0;
    end else begin
      if (accept) cur_tgt <= dec_tgt;
      if (accept && !s_r_valid_o)      outstanding <= outstanding + 4'd1;
      else if (!accept && s_r_valid_o) outstanding <= outstanding - 4'd1;
      unm_pend <= accept & dec_unmapped;
      if (accept && dec_unmapped) begin
        unm_rd <= s_wen_i;
        if (unmapped_cnt != 16'hFFFF) unmapped_cnt <= unmapped_cnt + 16'd1;
      end
    end
  end

  assign outstanding_o  = outstanding;
  assign unmapped_cnt_o = unmapped_cnt;

endmodule

// File: tb/tb_fc_addr_demux.sv
// Testbench for fc_addr_demux: directed scenarios followed by randomized
// traffic, all checked against a transaction-queue reference model.
module tb_fc_addr_demux;

  localparam int NP  = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int MO  = 4;
  localparam int UNM = NP;
  localparam logic [DW-1:0] ERR = 32'hBADA_CCE5;
  localparam logic [NP-1:0][AW-1:0] RS = {32'h1C08_0000, 32'h1C00_0000};
  localparam logic [NP-1:0][AW-1:0] RE = {32'h1C10_0000, 32'h1C08_0000};

  logic clk = 1'b0;
  logic rst;
  logic s_req, s_wen, s_gnt, s_r_valid, s_r_opc;
  logic [AW-1:0] s_add;
  logic [DW-1:0] s_wdata, s_r_rdata;
  logic [BW-1:0] s_be;
  logic [NP-1:0] m_req, m_wen, m_gnt, m_r_valid, m_r_opc;
  logic [NP-1:0][AW-1:0] m_add;
  logic [NP-1:0][DW-1:0] m_wdata, m_r_rdata;
  logic [NP-1:0][BW-1:0] m_be;
  logic [3:0]  outstanding;
  logic [15:0] unmapped_cnt;

  fc_addr_demux #(
    .N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO),
    .REGION_START(RS), .REGION_END(RE), .ERR_RDATA(ERR)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_req_i(s_req), .s_add_i(s_add), .s_wen_i(s_wen), .s_wdata_i(s_wdata), .s_be_i(s_be),
    .s_gnt_o(s_gnt), .s_r_valid_o(s_r_valid), .s_r_rdata_o(s_r_rdata), .s_r_opc_o(s_r_opc),
    .m_req_o(m_req), .m_add_o(m_add), .m_wen_o(m_wen), .m_wdata_o(m_wdata), .m_be_o(m_be),
    .m_gnt_i(m_gnt), .m_r_valid_i(m_r_valid), .m_r_rdata_i(m_r_rdata), .m_r_opc_i(m_r_opc),
    .outstanding_o(outstanding), .unmapped_cnt_o(unmapped_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: one queue entry per accepted, not-yet-answered request.
  typedef struct {
    int tgt;
    bit rd;
    int cyc;
  } txn_t;

  txn_t q[$];
  int   cyc = 0;
  int   unm_cnt_m = 0;
  int   checks = 0;
  int   failures = 0;

  // Values sampled from the DUT at the last check point, for directed checks.
  logic          last_gnt, last_rvalid, last_opc;
  logic [NP-1:0] last_mreq;
  logic [DW-1:0] last_rdata;
  int            dut_gnts, dut_rsps, dut_peak;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int i = 0; i < NP; i++) begin
      if (a >= RS[i] && a < RE[i]) return i;
    end
    return UNM;
  endfunction

  task automatic drive(input bit req, input logic [AW-1:0] a, input bit wen,
                       input logic [NP-1:0] g, input logic [NP-1:0] rv, input bit r = 1'b0);
    rst       = r;
    s_req     = req;
    s_add     = a;
    s_wen     = wen;
    s_wdata   = $urandom;
    s_be      = BW'($urandom);
    m_gnt     = g;
    m_r_valid = rv;
    for (int i = 0; i < NP; i++) begin
      m_r_rdata[i] = $urandom;
      m_r_opc[i]   = 1'($urandom);
    end
  endtask

  task automatic clear_stats();
    dut_gnts = 0;
    dut_rsps = 0;
    dut_peak = 0;
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance.
  task automatic tick();
    int            tgt;
    bit            stall, egnt, evalid;
    logic [NP-1:0] ereq;
    logic [DW-1:0] erdata;
    logic          eopc;
    #2;
    tgt   = decode(s_add);
    stall = (q.size() == MO) || (q.size() > 0 && q[$].tgt != tgt);
    egnt  = s_req && !stall && ((tgt == UNM) ? 1'b1 : m_gnt[tgt]);
    ereq  = '0;
    if (s_req && !stall && tgt != UNM) ereq[tgt] = 1'b1;
    evalid = 1'b0;
    erdata = '0;
    eopc   = 1'b0;
    if (q.size() > 0) begin
      if (q[0].tgt == UNM) begin
        evalid = (q[0].cyc == cyc - 1);
        erdata = q[0].rd ? ERR : '0;
        eopc   = 1'b1;
      end else begin
        evalid = m_r_valid[q[0].tgt];
        erdata = m_r_rdata[q[0].tgt];
        eopc   = m_r_opc[q[0].tgt];
      end
    end
    chk("s_gnt", s_gnt, egnt);
    chk("m_req", m_req, ereq);
    chk("s_r_valid", s_r_valid, evalid);
    if (evalid) begin
      chk("s_r_rdata", s_r_rdata, erdata);
      chk("s_r_opc", s_r_opc, eopc);
    end
    chk("outstanding", outstanding, q.size());
    chk("unmapped_cnt", unmapped_cnt, unm_cnt_m);
    for (int i = 0; i < NP; i++) begin
      chk("m_add_bcast", m_add[i], s_add);
      chk("m_wdata_bcast", {m_wen[i], m_be[i], m_wdata[i]}, {s_wen, s_be, s_wdata});
    end
    last_gnt    = s_gnt;
    last_mreq   = m_req;
    last_rvalid = s_r_valid;
    last_rdata  = s_r_rdata;
    last_opc    = s_r_opc;
    if (s_gnt === 1'b1) dut_gnts++;
    if (s_r_valid === 1'b1) dut_rsps++;
    if (int'(outstanding) > dut_peak) dut_peak = int'(outstanding);
    @(posedge clk);
    if (rst) begin
      q.delete();
      unm_cnt_m = 0;
    end else begin
      if (evalid) void'(q.pop_front());
      if (egnt) begin
        q.push_back('{tgt: tgt, rd: s_wen, cyc: cyc});
        if (tgt == UNM && unm_cnt_m < 16'hFFFF) unm_cnt_m++;
      end
    end
    cyc++;
    #1;
  endtask

  logic [AW-1:0] edges [6] = '{32'h1BFF_FFFC, 32'h1C00_0000, 32'h1C07_FFFC,
                               32'h1C08_0000, 32'h1C0F_FFFC, 32'h1C10_0000};

  initial begin
    logic [AW-1:0] a;
    clear_stats();

    // Reset; first edge initialises the DUT, second is checked.
    drive(1'b0, '0, 1'b1, '0, '0, 1'b1);
    @(posedge clk);
    #1;
    tick();
    drive(1'b0, '0, 1'b1, '0, '0);
    tick();
    chk("reset_outstanding", outstanding, 0);
    chk("reset_rvalid", last_rvalid, 0);
    chk("reset_gnt_no_req", last_gnt, 0);

    // Four back-to-back reads, port answers one cycle later.
    clear_stats();
    for (int k = 0; k < 5; k++) begin
      drive(k < 4, 32'h1C00_0010, 1'b1, 2'b01, (k > 0) ? 2'b01 : 2'b00);
      tick();
    end
    chk("b2b_grants", dut_gnts, 4);
    chk("b2b_responses", dut_rsps, 4);
    chk("b2b_peak", dut_peak, 1);

    // Port0 holds responses: fifth read stalls at MAX_OUTSTANDING.
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 32'h1C00_0020, 1'b1, 2'b01, 2'b00);
      tick();
    end
    chk("full_stall_gnt", last_gnt, 0);
    chk("full_outstanding", outstanding, 4);
    drive(1'b1, 32'h1C00_0020, 1'b1, 2'b01, 2'b01);
    tick();
    chk("full_gnt_at_rsp", last_gnt, 0);
    chk("full_after_rsp", outstanding, 3);
    drive(1'b1, 32'h1C00_0020, 1'b1, 2'b01, 2'b00);
    tick();
    chk("full_fifth_granted", last_gnt, 1);
    chk("full_refilled", outstanding, 4);
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 32'h1C00_0020, 1'b1, 2'b00, 2'b01);
      tick();
    end
    chk("full_drained", outstanding, 0);

    // Target switch waits until the previous target is drained.
    drive(1'b1, 32'h1C00_0000, 1'b1, 2'b11, 2'b00);
    tick();
    drive(1'b1, 32'h1C08_0000, 1'b1, 2'b11, 2'b00);
    tick();
    chk("switch_stall_gnt", last_gnt, 0);
    chk("switch_stall_mreq", last_mreq, 2'b00);
    drive(1'b1, 32'h1C08_0000, 1'b1, 2'b11, 2'b01);
    tick();
    chk("switch_gnt_at_drain", last_gnt, 0);
    drive(1'b1, 32'h1C08_0000, 1'b1, 2'b11, 2'b00);
    tick();
    chk("switch_granted", last_gnt, 1);
    chk("switch_mreq_port1", last_mreq, 2'b10);
    drive(1'b0, 32'h1C08_0000, 1'b1, 2'b00, 2'b10);
    tick();
    chk("switch_port1_rsp", last_rvalid, 1);

    // Unmapped read and write.
    drive(1'b1, 32'h0000_0000, 1'b1, 2'b00, 2'b00);
    tick();
    chk("unm_rd_gnt", last_gnt, 1);
    drive(1'b0, 32'h0000_0000, 1'b1, 2'b00, 2'b00);
    tick();
    chk("unm_rd_valid", last_rvalid, 1);
    chk("unm_rd_opc", last_opc, 1);
    chk("unm_rd_rdata", last_rdata, 32'hBADA_CCE5);
    chk("unm_rd_cnt", unmapped_cnt, 1);
    drive(1'b1, 32'h2000_0000, 1'b0, 2'b00, 2'b00);
    tick();
    drive(1'b0, 32'h2000_0000, 1'b0, 2'b00, 2'b00);
    tick();
    chk("unm_wr_valid", last_rvalid, 1);
    chk("unm_wr_rdata", last_rdata, 0);
    chk("unm_wr_cnt", unmapped_cnt, 2);

    // Spurious response from a non-current port.
    drive(1'b1, 32'h1C00_0040, 1'b1, 2'b01, 2'b00);
    tick();
    drive(1'b0, 32'h1C00_0040, 1'b1, 2'b00, 2'b10);
    tick();
    chk("spurious_no_valid", last_rvalid, 0);
    chk("spurious_outstanding", outstanding, 1);
    drive(1'b0, 32'h1C00_0040, 1'b1, 2'b00, 2'b01);
    tick();
    chk("spurious_real_rsp", last_rvalid, 1);

    // Reset with three requests in flight; late response ignored.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h1C00_0000, 1'b1, 2'b01, 2'b00);
      tick();
    end
    chk("rst_mid_before", outstanding, 3);
    drive(1'b0, 32'h1C00_0000, 1'b1, 2'b00, 2'b00, 1'b1);
    tick();
    chk("rst_mid_cleared", outstanding, 0);
    drive(1'b0, 32'h1C00_0000, 1'b1, 2'b00, 2'b01);
    tick();
    chk("rst_late_rsp_ignored", last_rvalid, 0);

    // Randomized traffic including window edges, spurious responses, resets.
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 5))
        0, 1: a = 32'h1C00_0000 + AW'($urandom_range(0, 32'h1FFFF) << 2);
        2, 3: a = 32'h1C08_0000 + AW'($urandom_range(0, 32'h1FFFF) << 2);
        4:    a = edges[$urandom_range(0, 5)];
        default: a = $urandom;
      endcase
      drive($urandom_range(0, 9) < 7, a, 1'($urandom), NP'($urandom), NP'($urandom),
            $urandom_range(0, 63) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
